branch_target_table: RTL and testbench

//  Programmable successor to the fixed label->next_pc lookup. Maps a branch

---
 rtl/branch_target_table.sv | 175 +++++++++++++++++
 tb/tb_branch_target_table.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_table.sv
// Branch target table: writable label -> target PC map with per-entry valid
// bits, registered single-cycle lookups, and a sequential whole-table clear
// that sweeps one entry per cycle.
module branch_target_table #(
    parameter int              LABEL_W    = 8,
    parameter int              PC_W       = 12,
    parameter int              DEPTH      = 64,
    parameter logic [PC_W-1:0] DEFAULT_PC = {PC_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_req,
    output logic                       busy,
    input  logic                       wr_en,
    input  logic [LABEL_W-1:0]         wr_label,
    input  logic [PC_W-1:0]            wr_pc,
    output logic                       wr_err,
    input  logic                       rd_en,
    input  logic [LABEL_W-1:0]         rd_label,
    output logic                       rd_ready,
    output logic                       rsp_valid,
    output logic                       rsp_hit,
    output logic [PC_W-1:0]            rsp_pc,
    output logic [$clog2(DEPTH+1)-1:0] entry_count
);

    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [LABEL_W:0] DEPTH_V  = (LABEL_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PC_W-1:0]   pc_mem_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
    logic              wr_err_q, wr_err_d;

    logic              wr_in_range_s, rd_in_range_s;
    logic              wr_ok_s, rd_acc_s;
    logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
    logic              rd_hit_s;
    logic [PC_W-1:0]   rd_pc_s;

    assign wr_in_range_s = ({1'b0, wr_label} < DEPTH_V);
    assign rd_in_range_s = ({1'b0, rd_label} < DEPTH_V);
    assign wr_idx_s      = wr_label[IDX_W-1:0];
    assign rd_idx_s      = rd_label[IDX_W-1:0];
    // A clear request in the same cycle wins over a write.
    assign wr_ok_s       = wr_en && (state_q == ST_READY) && !clear_req && wr_in_range_s;
    assign rd_acc_s      = rd_en && (state_q == ST_READY);

    // Lookup result with write-first bypass for a same-cycle write to the same label.
    always_comb begin
        rd_hit_s = 1'b0;
        rd_pc_s  = DEFAULT_PC;
        if (!rd_in_range_s) begin
            rd_hit_s = 1'b0;
            rd_pc_s  = DEFAULT_PC;
        end else if (wr_ok_s && (wr_idx_s == rd_idx_s)) begin
            rd_hit_s = 1'b1;
            rd_pc_s  = wr_pc;
        end else if (valid_q[rd_idx_s]) begin
            rd_hit_s = 1'b1;
            rd_pc_s  = pc_mem_q[rd_idx_s];
        end else begin
            rd_hit_s = 1'b0;
            rd_pc_s  = DEFAULT_PC;
        end
    end

    // Next-state logic: FSM, clear sweep, valid bits and entry count.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                valid_d[clr_idx_q] = 1'b0;
                if (clear_req) begin
                    clr_idx_d = {IDX_W{1'b0}};
                end else if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_READY;
                    clr_idx_d = {IDX_W{1'b0}};
                end else begin
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = {IDX_W{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                end else if (wr_ok_s) begin
                    valid_d[wr_idx_s] = 1'b1;
                    if (!valid_q[wr_idx_s]) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = {IDX_W{1'b0}};
                cnt_d     = {CNT_W{1'b0}};
            end
        endcase
    end

    // Response and write-error next values; response fields hold when idle.
    always_comb begin
        rsp_valid_d = rd_acc_s;
        rsp_hit_d   = rsp_hit_q;
        rsp_pc_d    = rsp_pc_q;
        wr_err_d    = wr_en && !wr_ok_s;
        if (rd_acc_s) begin
            rsp_hit_d = rd_hit_s;
            rsp_pc_d  = rd_pc_s;
        end else begin
            rsp_hit_d = rsp_hit_q;
            rsp_pc_d  = rsp_pc_q;
        end
    end

    // Control, valid and response registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= {IDX_W{1'b0}};
            valid_q     <= {DEPTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_pc_q    <= DEFAULT_PC;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_pc_q    <= rsp_pc_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Target PC storage; contents are qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            pc_mem_q[wr_idx_s] <= wr_pc;
        end
    end

    assign busy        = (state_q == ST_CLEAR);
    assign rd_ready    = (state_q == ST_READY);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_pc      = rsp_pc_q;
    assign wr_err      = wr_err_q;
    assign entry_count = cnt_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table: a reference model of the table
// predicts each lookup response, which is queued at request time and compared
// when the DUT strobes rsp_valid.
module tb_branch_target_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic        busy;
    logic        wr_en;
    logic [7:0]  wr_label;
    logic [11:0] wr_pc;
    logic        wr_err;
    logic        rd_en;
    logic [7:0]  rd_label;
    logic        rd_ready;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [11:0] rsp_pc;
    logic [6:0]  entry_count;

    typedef struct packed {
        logic        hit;
        logic [11:0] pc;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model of the table
    bit          m_valid [64];
    logic [11:0] m_pc    [64];
    int          m_count;
    bit          model_ready;

    branch_target_table dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_label   (wr_label),
        .wr_pc      (wr_pc),
        .wr_err     (wr_err),
        .rd_en      (rd_en),
        .rd_label   (rd_label),
        .rd_ready   (rd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_pc     (rsp_pc),
        .entry_count(entry_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = 12'd0;
        end
        m_count     = 0;
        model_ready = 1'b0;
    endtask

    // One clock cycle of stimulus; the model predicts the response and wr_err.
    task automatic cycle(input bit we, input int wl, input int wp,
                         input bit re, input int rl, input bit clr);
        bit   acc;
        rsp_t e;
        acc = we && model_ready && !clr && (wl < 64);
        if (model_ready && re) begin
            if (rl >= 64) begin
                e.hit = 1'b0; e.pc = 12'd0;
            end else if (acc && (wl == rl)) begin
                e.hit = 1'b1; e.pc = wp[11:0];
            end else if (m_valid[rl]) begin
                e.hit = 1'b1; e.pc = m_pc[rl];
            end else begin
                e.hit = 1'b0; e.pc = 12'd0;
            end
            exp_q.push_back(e);
        end
        wr_en     = we;
        wr_label  = wl[7:0];
        wr_pc     = wp[11:0];
        rd_en     = re;
        rd_label  = rl[7:0];
        clear_req = clr;
        @(posedge clk);
        if (acc) begin
            if (!m_valid[wl]) m_count++;
            m_valid[wl] = 1'b1;
            m_pc[wl]    = wp[11:0];
        end
        if (clr && model_ready) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_count     = 0;
            model_ready = 1'b0;
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
        check_eq("wr_err", wr_err, we && !acc);
        check_eq("entry_count", entry_count, m_count);
    endtask

    // Count busy cycles (sampled 1 time unit after each edge), bounded.
    task automatic wait_clear(input int exp_n);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            check_eq("rd_ready_busy", rd_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        check_eq("clear_len", n, exp_n);
        check_eq("count_after_clear", entry_count, 0);
        check_eq("rd_ready_after_clear", rd_ready, 1'b1);
        model_ready = 1'b1;
    endtask

    // Response monitor: pops expectations on rsp_valid, checks hold otherwise.
    initial begin
        rsp_t        e;
        logic        last_hit;
        logic [11:0] last_pc;
        last_hit = 1'b0;
        last_pc  = 12'd0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                last_hit = 1'b0;
                last_pc  = 12'd0;
            end else if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_spurious", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_hit", rsp_hit, e.hit);
                    check_eq("rsp_pc", rsp_pc, e.pc);
                    last_hit = e.hit;
                    last_pc  = e.pc;
                end
            end else begin
                check_eq("rsp_hit_hold", rsp_hit, last_hit);
                check_eq("rsp_pc_hold", rsp_pc, last_pc);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clear_req = 1'b0; wr_en = 1'b0; wr_label = 8'd0;
        wr_pc = 12'd0; rd_en = 1'b0; rd_label = 8'd0;
        model_reset();
        #3;
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_rd_ready", rd_ready, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_hit", rsp_hit, 1'b0);
        check_eq("rst_rsp_pc", rsp_pc, 12'd0);
        check_eq("rst_wr_err", wr_err, 1'b0);
        check_eq("rst_count", entry_count, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear(64);

        // Basic write / lookup hit / miss
        cycle(1, 3, 205, 0, 0, 0);
        cycle(0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 1, 4, 0);
        // Same-cycle write and lookup bypass, then overwrite
        cycle(1, 5, 231, 1, 5, 0);
        cycle(1, 5, 244, 0, 0, 0);
        cycle(0, 0, 0, 1, 5, 0);
        // Out-of-range write and lookup
        cycle(1, 70, 100, 0, 0, 0);
        cycle(0, 0, 0, 1, 70, 0);
        cycle(1, 64, 9, 1, 64, 0);
        // Last valid label
        cycle(0, 0, 0, 1, 63, 0);
        cycle(1, 63, 4095, 0, 0, 0);
        cycle(0, 0, 0, 1, 63, 0);
        // Fill 10 entries, then back-to-back lookups
        for (int i = 0; i < 10; i++) cycle(1, 10 + i, 100 + i * 37, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 10 + i, 0);
        cycle(0, 0, 0, 1, 3, 0);
        // Clear with same-cycle lookup (pre-clear contents) and dropped write
        cycle(1, 20, 555, 1, 12, 1);
        // Write and lookup during CLEAR: write dropped, lookup ignored
        cycle(1, 7, 99, 1, 12, 0);
        wait_clear(63);
        // Everything misses after the clear
        cycle(0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 1, 5, 0);
        cycle(0, 0, 0, 1, 7, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 10 + i, 0);
        cycle(0, 0, 0, 1, 20, 0);
        cycle(0, 0, 0, 1, 63, 0);

        // Reset mid-clear at clr_idx 20
        cycle(1, 30, 77, 0, 0, 0);
        cycle(0, 0, 0, 1, 30, 0);
        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 1'b1);
        check_eq("midrst_rd_ready", rd_ready, 1'b0);
        check_eq("midrst_rsp_valid", rsp_valid, 1'b0);
        check_eq("midrst_rsp_hit", rsp_hit, 1'b0);
        check_eq("midrst_rsp_pc", rsp_pc, 12'd0);
        check_eq("midrst_wr_err", wr_err, 1'b0);
        check_eq("midrst_count", entry_count, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear(64);
        cycle(0, 0, 0, 1, 30, 0);
        cycle(1, 40, 1234, 1, 40, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
